// File: rtl/neuron.sv
// rtl/neuron.sv - time-multiplexed fixed-point neuron, y = sat(sum(x*w) >>> FRAC + bias)
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset (0 = reset)
//   input_data     N packed signed inputs, x_i at [i*R +: R]
//   weight         N packed signed weights, w_i at [i*R +: R]
//   bias           signed bias, output Q-format
//   output_neuron  signed registered output, updated once per N-cycle sweep

module neuron #(
    parameter int input_data_size = 1,
    parameter int resolution      = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [input_data_size*resolution-1:0]   input_data,
    input  logic [input_data_size*resolution-1:0]   weight,
    input  logic [resolution-1:0]                   bias,
    output logic [resolution-1:0]                   output_neuron
);

    localparam int N    = input_data_size;
    localparam int R    = resolution;
    localparam int FRAC = R - 1;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    // Sum of N full-width products plus one guard bit can never overflow.
    localparam int AW   = 2 * R + $clog2(N) + 1;

    localparam logic [CW-1:0]        LAST = CW'(N - 1);
    localparam logic signed [AW-1:0] MAXV = {{(AW-R+1){1'b0}}, {(R-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-R+1){1'b1}}, {(R-1){1'b0}}};

    logic [CW-1:0]          cnt;
    logic signed [AW-1:0]   acc;

    logic signed [R-1:0]    x_sel;
    logic signed [R-1:0]    w_sel;
    logic signed [2*R-1:0]  prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW-1:0]   acc_next;
    logic signed [AW-1:0]   bias_ext;
    logic signed [AW-1:0]   shifted;
    logic signed [AW-1:0]   total;
    logic [R-1:0]           sat_val;

    always_comb begin
        x_sel    = input_data[int'(cnt)*R +: R];
        w_sel    = weight[int'(cnt)*R +: R];
        prod     = x_sel * w_sel;
        prod_ext = {{(AW-2*R){prod[2*R-1]}}, prod};
        // Index 0 starts a fresh sweep, discarding the previous total.
        acc_next = (cnt == '0) ? prod_ext : acc + prod_ext;
        bias_ext = {{(AW-R){bias[R-1]}}, bias};
        // Arithmetic shift floors toward -inf; bias joins after scaling.
        shifted  = acc_next >>> FRAC;
        total    = shifted + bias_ext;
        if (total > MAXV) begin
            sat_val = MAXV[R-1:0];
        end else if (total < MINV) begin
            sat_val = MINV[R-1:0];
        end else begin
            sat_val = total[R-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            acc           <= '0;
            output_neuron <= '0;
        end else begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            acc <= acc_next;
            if (cnt == LAST) begin
                output_neuron <= sat_val;
            end
        end
    end

endmodule

// File: tb/tb_neuron.sv
// tb/tb_neuron.sv - randomized self-checking bench for neuron (N=1 and N=4 instances)

module tb_neuron;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst4;
    logic [7:0]  x1, w1, b1, o1;
    logic [31:0] x4, w4;
    logic [7:0]  b4, o4;

    neuron #(.input_data_size(1), .resolution(8)) u1 (
        .clk(clk), .reset(rst1), .input_data(x1), .weight(w1),
        .bias(b1), .output_neuron(o1)
    );

    neuron #(.input_data_size(4), .resolution(8)) u4 (
        .clk(clk), .reset(rst4), .input_data(x4), .weight(w4),
        .bias(b4), .output_neuron(o4)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact integer dot product, floor-divide by 2^7, add bias, clamp.
    function automatic int ref_out(input int n, input int xs[4], input int ws[4], input int b);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(xs[i]) * longint'(ws[i]);
        s = s >>> 7;
        s += b;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return int'(s);
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    int xa[4], wa[4];
    int ba;

    task automatic apply1(input string tag, input int x, input int w, input int b);
        int xs[4], ws[4];
        xs = '{x, 0, 0, 0};
        ws = '{w, 0, 0, 0};
        @(negedge clk);
        x1 = 8'(x); w1 = 8'(w); b1 = 8'(b);
        @(negedge clk);
        check(tag, int'($signed(o1)), ref_out(1, xs, ws, b));
    endtask

    task automatic drive4();
        for (int i = 0; i < 4; i++) begin
            x4[i*8 +: 8] = 8'(xa[i]);
            w4[i*8 +: 8] = 8'(wa[i]);
        end
        b4 = 8'(ba);
    endtask

    // One full sweep: output holds prev for 3 edges, shows nxt after the 4th.
    task automatic sweep4(input string tag, input int prev, input int nxt);
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            check(tag, int'($signed(o4)), (e == 3) ? nxt : prev);
        end
    endtask

    int dx[7] = '{-128, -128, -128,  64, -128, -1, 1};
    int dw[7] = '{-128, -128, -128, -64,  127,  1, 1};
    int db[7] = '{ 127,    5,   -3,   0, -128,  0, 0};

    initial begin
        int prev, nxt;
        rst1 = 1'b0; rst4 = 1'b0;
        x1 = '0; w1 = '0; b1 = '0;
        x4 = '0; w4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        check("reset_o1", int'($signed(o1)), 0);
        check("reset_o4", int'($signed(o4)), 0);

        // N=1 directed cases
        rst1 = 1'b1;
        for (int i = 0; i < 7; i++) apply1("n1_directed", dx[i], dw[i], db[i]);
        for (int i = 0; i < 30; i++) apply1("n1_random", rnd8(), rnd8(), rnd8());

        // N=1 asynchronous reset between edges
        apply1("n1_pre_rst", -128, -128, 127);
        #2 rst1 = 1'b0;
        #1 check("n1_async_rst", int'($signed(o1)), 0);
        @(negedge clk);
        check("n1_rst_held", int'($signed(o1)), 0);
        rst1 = 1'b1;
        @(negedge clk);
        check("n1_post_rst", int'($signed(o1)), 127);

        // N=4: constant inputs, output written only at end of sweep
        for (int i = 0; i < 4; i++) begin xa[i] = 64; wa[i] = 64; end
        ba = -1;
        @(negedge clk);
        drive4();
        rst4 = 1'b1;
        sweep4("n4_const", 0, 127);
        sweep4("n4_hold", 127, 127);

        // N=4: weight 0 changes mid-sweep after its use
        @(negedge clk); check("n4_mid_hold", int'($signed(o4)), 127);
        @(negedge clk); check("n4_mid_hold", int'($signed(o4)), 127);
        wa[0] = -64;
        drive4();
        @(negedge clk); check("n4_mid_hold", int'($signed(o4)), 127);
        @(negedge clk); check("n4_mid_old", int'($signed(o4)), 127);
        nxt = ref_out(4, xa, wa, ba);
        check("n4_mid_model", nxt, 63);
        sweep4("n4_mid_new", 127, nxt);
        prev = nxt;

        // N=4 random sweeps
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 4; i++) begin xa[i] = rnd8(); wa[i] = rnd8(); end
            ba = rnd8();
            drive4();
            nxt = ref_out(4, xa, wa, ba);
            sweep4("n4_random", prev, nxt);
            prev = nxt;
        end

        // N=4 reset mid-sweep discards the partial sum
        for (int i = 0; i < 4; i++) begin xa[i] = rnd8(); wa[i] = rnd8(); end
        ba = rnd8();
        drive4();
        @(negedge clk); check("n4_pre_rst", int'($signed(o4)), prev);
        @(negedge clk); check("n4_pre_rst", int'($signed(o4)), prev);
        #2 rst4 = 1'b0;
        #1 check("n4_async_rst", int'($signed(o4)), 0);
        @(negedge clk);
        rst4 = 1'b1;
        sweep4("n4_post_rst", 0, ref_out(4, xa, wa, ba));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
